fetch_stage: RTL and testbench

- Instruction-fetch stage of riscv_core; sits directly upstream of the decode stage and drives the IF/ID pipeline register that decode consumes.
- Owns the PC, issues requests to instruction memory, and buffers returned instructions in a small FIFO so memory latency is decoupled from decode stalls.
- Accepts stall from the hazard unit and flush/redirect from branch resolution in EX.

---
 rtl/fetch_stage.sv | 189 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage with instruction buffer; optional FETCH_PERF_CNT_EN adds perf counters.
// fetch_fifo is the generic clearable buffer used by fetch_stage.

// fetch_fifo: power-of-two circular buffer with synchronous clear.
// Latency: data pushed on edge E is visible at the head after E (no bypass).
// Backpressure: pushes while full are ignored; pops only when pop_vld && pop_rdy.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   push_vld,
    input  logic [WIDTH-1:0]       push_dat,
    output logic                   pop_vld,
    input  logic                   pop_rdy,
    output logic [WIDTH-1:0]       pop_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign pop_vld = (count != '0);
    assign pop_dat = mem[rd_ptr];
    assign do_push = push_vld && (count != (PW+1)'(DEPTH));
    assign do_pop  = pop_vld && pop_rdy;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
endmodule

// fetch_stage: owns the PC, issues one imem request at a time, buffers responses, drives IF/ID.
// Latency: grant to if_id_valid_o = memory latency + 1 cycle.
// Backpressure: stall_i holds IF/ID; requests pause while the buffer is full or a request is outstanding.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_id_valid_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc_plus4_o,
    output logic [31:0] if_id_instr_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_flushed_o,
    output logic [31:0] perf_stall_o
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   pc;
    logic [31:0]   req_pc;
    logic          outstanding;
    logic          drop;
    logic          run;
    logic          rsp_vld;
    logic          push_vld;
    logic          pop_rdy;
    logic          head_vld;
    logic [63:0]   head_dat;
    logic [CW-1:0] fifo_cnt;
    logic          grant;

    // run keeps the request line low through reset and the first edge after it
    assign rsp_vld     = imem_rvalid_i && outstanding;
    assign push_vld    = rsp_vld && !drop && !flush_i;
    assign pop_rdy     = !flush_i && !stall_i;
    assign imem_req_o  = run && !outstanding && !flush_i && (fifo_cnt < CW'(FIFO_DEPTH));
    assign imem_addr_o = pc;
    assign grant       = imem_req_o && imem_gnt_i;

    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (flush_i),
        .push_vld (push_vld),
        .push_dat ({req_pc, imem_rdata_i}),
        .pop_vld  (head_vld),
        .pop_rdy  (pop_rdy),
        .pop_dat  (head_dat),
        .count    (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC & 32'hFFFF_FFFC;
            req_pc      <= '0;
            outstanding <= 1'b0;
            drop        <= 1'b0;
            run         <= 1'b0;
        end else begin
            run <= 1'b1;
            if (flush_i)
                pc <= redirect_pc_i & 32'hFFFF_FFFC;
            else if (grant) begin
                pc     <= pc + 32'd4;
                req_pc <= pc;
            end
            if (grant)
                outstanding <= 1'b1;
            else if (rsp_vld)
                outstanding <= 1'b0;
            // a response landing on the flush edge is simply not pushed, so no drop is owed
            if (flush_i)
                drop <= outstanding && !imem_rvalid_i;
            else if (rsp_vld)
                drop <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_valid_o    <= 1'b0;
            if_id_pc_o       <= '0;
            if_id_pc_plus4_o <= '0;
            if_id_instr_o    <= NOP_INSTR;
        end else if (flush_i) begin
            if_id_valid_o <= 1'b0;
            if_id_instr_o <= NOP_INSTR;
        end else if (!stall_i) begin
            if (head_vld) begin
                if_id_valid_o    <= 1'b1;
                if_id_pc_o       <= head_dat[63:32];
                if_id_pc_plus4_o <= head_dat[63:32] + 32'd4;
                if_id_instr_o    <= head_dat[31:0];
            end else begin
                if_id_valid_o <= 1'b0;
                if_id_instr_o <= NOP_INSTR;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_o <= '0;
            perf_flushed_o <= '0;
            perf_stall_o   <= '0;
        end else begin
            perf_fetched_o <= perf_fetched_o + 32'(push_vld);
            perf_flushed_o <= perf_flushed_o + 32'(flush_i);
            perf_stall_o   <= perf_stall_o + 32'(stall_i && if_id_valid_o);
        end
    end
`else
    // Counters compiled out; fetch behaviour is unchanged.
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural single-port instruction memory (word = addr | 0x13).
module tb_fetch_stage;
    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_id_valid_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc_plus4_o;
    logic [31:0] if_id_instr_o;

    int tests = 0;
    int fails = 0;

    // memory model knobs
    int          lat    = 1;
    bit          gnt_en = 1'b1;
    bit          pend   = 1'b0;
    bit          granted = 1'b0;
    int          cnt    = 0;
    logic [31:0] pend_addr;
    logic [31:0] gnt_addr;

    fetch_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_gnt_i       (imem_gnt_i),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .if_id_valid_o    (if_id_valid_o),
        .if_id_pc_o       (if_id_pc_o),
        .if_id_pc_plus4_o (if_id_pc_plus4_o),
        .if_id_instr_o    (if_id_instr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory ignores the DUT reset on purpose so a stale response can arrive afterwards.
    initial begin
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        pend_addr     = '0;
        gnt_addr      = '0;
        forever begin
            @(negedge clk);
            if (imem_rvalid_i) begin
                imem_rvalid_i = 1'b0;
                pend = 1'b0;
            end
            if (granted) begin
                pend = 1'b1;
                cnt = lat;
                pend_addr = gnt_addr;
                granted = 1'b0;
            end
            if (pend && !imem_rvalid_i) begin
                cnt = cnt - 1;
                if (cnt <= 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = pend_addr | 32'h13;
                end
            end
            imem_gnt_i = gnt_en && !pend;
            granted    = (imem_req_o === 1'b1) && imem_gnt_i;
            gnt_addr   = imem_addr_o;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (if_id_valid_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (imem_req_o === 1'b1 && imem_gnt_i === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #2;
        tests++; if (if_id_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0h expected 0", if_id_valid_o); end
        tests++; if (if_id_pc_o !== 32'h0) begin fails++; $display("FAIL reset_pc: got %0h expected 0", if_id_pc_o); end
        tests++; if (if_id_pc_plus4_o !== 32'h0) begin fails++; $display("FAIL reset_pc4: got %0h expected 0", if_id_pc_plus4_o); end
        tests++; if (if_id_instr_o !== 32'h13) begin fails++; $display("FAIL reset_instr: got %0h expected 13", if_id_instr_o); end
        tests++; if (imem_req_o !== 1'b0) begin fails++; $display("FAIL reset_req: got %0h expected 0", imem_req_o); end
    endtask

    task automatic test_stream();
        bit ok;
        @(posedge clk); #1 rst_n = 1'b1;
        wait_grant(ok);
        tests++; if (!ok || imem_addr_o !== 32'h0) begin fails++; $display("FAIL first_grant: got ok=%0d addr=%0h expected addr 0", ok, imem_addr_o); end
        step();
        step();
        tests++; if (if_id_valid_o !== 1'b0) begin fails++; $display("FAIL lat_early: got valid=%0h expected 0", if_id_valid_o); end
        step();
        tests++; if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h0) begin fails++; $display("FAIL lat_two: got valid=%0h pc=%0h expected 1/0", if_id_valid_o, if_id_pc_o); end
        tests++; if (if_id_pc_plus4_o !== 32'h4 || if_id_instr_o !== 32'h13) begin fails++; $display("FAIL first_data: got pc4=%0h instr=%0h expected 4/13", if_id_pc_plus4_o, if_id_instr_o); end
        wait_valid(ok);
        tests++; if (!ok || if_id_pc_o !== 32'h4 || if_id_instr_o !== 32'h17 || if_id_pc_plus4_o !== 32'h8) begin fails++; $display("FAIL stream_pc4: got pc=%0h instr=%0h pc4=%0h expected 4/17/8", if_id_pc_o, if_id_instr_o, if_id_pc_plus4_o); end
    endtask

    task automatic test_stall();
        bit ok;
        wait_valid(ok);
        tests++; if (!ok || if_id_pc_o !== 32'h8) begin fails++; $display("FAIL stream_pc8: got pc=%0h expected 8", if_id_pc_o); end
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            tests++; if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h8) begin fails++; $display("FAIL stall_hold: got valid=%0h pc=%0h expected 1/8", if_id_valid_o, if_id_pc_o); end
        end
        tests++; if (imem_req_o !== 1'b0) begin fails++; $display("FAIL stall_full_req: got %0h expected 0", imem_req_o); end
        stall_i = 1'b0;
        step();
        tests++; if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'hc || if_id_instr_o !== 32'h1f) begin fails++; $display("FAIL stall_rel12: got valid=%0h pc=%0h instr=%0h expected 1/c/1f", if_id_valid_o, if_id_pc_o, if_id_instr_o); end
        step();
        tests++; if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h10) begin fails++; $display("FAIL stall_rel16: got valid=%0h pc=%0h expected 1/10", if_id_valid_o, if_id_pc_o); end
    endtask

    task automatic test_flush();
        bit ok;
        bit seen;
        lat = 3;
        wait_grant(ok);
        tests++; if (!ok) begin fails++; $display("FAIL flush_grant: got no grant expected one"); end
        @(posedge clk); #1;
        flush_i = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        #1;
        tests++; if (imem_req_o !== 1'b0) begin fails++; $display("FAIL flush_req: got %0h expected 0", imem_req_o); end
        @(posedge clk); #1;
        flush_i = 1'b0;
        tests++; if (if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h13) begin fails++; $display("FAIL flush_ifid: got valid=%0h instr=%0h expected 0/13", if_id_valid_o, if_id_instr_o); end
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            step();
            if (imem_req_o === 1'b1) seen = 1'b1;
        end
        tests++; if (!seen || imem_addr_o !== 32'h100) begin fails++; $display("FAIL redirect_addr: got seen=%0d addr=%0h expected 100", seen, imem_addr_o); end
        wait_valid(ok);
        tests++; if (!ok || if_id_pc_o !== 32'h100 || if_id_instr_o !== 32'h113) begin fails++; $display("FAIL redirect_first: got pc=%0h instr=%0h expected 100/113", if_id_pc_o, if_id_instr_o); end
    endtask

    task automatic test_flush_stall();
        bit ok;
        lat = 1;
        wait_valid(ok);
        @(posedge clk); #1;
        flush_i = 1'b1;
        stall_i = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        @(posedge clk); #1;
        tests++; if (if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h13) begin fails++; $display("FAIL fs_ifid: got valid=%0h instr=%0h expected 0/13", if_id_valid_o, if_id_instr_o); end
        flush_i = 1'b0;
        stall_i = 1'b0;
        wait_valid(ok);
        tests++; if (!ok || if_id_pc_o !== 32'h200 || if_id_instr_o !== 32'h213) begin fails++; $display("FAIL fs_resume: got pc=%0h instr=%0h expected 200/213", if_id_pc_o, if_id_instr_o); end
    endtask

    task automatic test_no_grant();
        bit ok;
        bit seen;
        logic [31:0] a;
        @(posedge clk); #1;
        gnt_en = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            step();
            if (imem_req_o === 1'b1) seen = 1'b1;
        end
        a = imem_addr_o;
        tests++; if (!seen) begin fails++; $display("FAIL ng_req: got no request expected one"); end
        for (int i = 0; i < 4; i++) begin
            step();
            tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== a) begin fails++; $display("FAIL ng_stable: got req=%0h addr=%0h expected 1/%0h", imem_req_o, imem_addr_o, a); end
        end
        tests++; if (if_id_valid_o !== 1'b0) begin fails++; $display("FAIL ng_valid: got %0h expected 0", if_id_valid_o); end
        gnt_en = 1'b1;
        wait_valid(ok);
        tests++; if (!ok || if_id_pc_o !== a) begin fails++; $display("FAIL ng_resume: got pc=%0h expected %0h", if_id_pc_o, a); end
        wait_valid(ok);
        tests++; if (!ok || if_id_pc_o !== a + 32'd4) begin fails++; $display("FAIL ng_next: got pc=%0h expected %0h", if_id_pc_o, a + 32'd4); end
    endtask

    task automatic test_reset_midstream();
        bit ok;
        lat = 3;
        wait_grant(ok);
        tests++; if (!ok) begin fails++; $display("FAIL rm_grant: got no grant expected one"); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        tests++; if (if_id_valid_o !== 1'b0 || if_id_pc_o !== 32'h0 || if_id_pc_plus4_o !== 32'h0) begin fails++; $display("FAIL rm_regs: got valid=%0h pc=%0h pc4=%0h expected 0/0/0", if_id_valid_o, if_id_pc_o, if_id_pc_plus4_o); end
        tests++; if (if_id_instr_o !== 32'h13 || imem_req_o !== 1'b0) begin fails++; $display("FAIL rm_instr_req: got instr=%0h req=%0h expected 13/0", if_id_instr_o, imem_req_o); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_valid(ok);
        tests++; if (!ok || if_id_pc_o !== 32'h0 || if_id_instr_o !== 32'h13 || if_id_pc_plus4_o !== 32'h4) begin fails++; $display("FAIL rm_restart: got pc=%0h instr=%0h pc4=%0h expected 0/13/4", if_id_pc_o, if_id_instr_o, if_id_pc_plus4_o); end
        wait_valid(ok);
        tests++; if (!ok || if_id_pc_o !== 32'h4 || if_id_instr_o !== 32'h17) begin fails++; $display("FAIL rm_second: got pc=%0h instr=%0h expected 4/17", if_id_pc_o, if_id_instr_o); end
    endtask

    initial begin
        rst_n         = 1'b1;
        stall_i       = 1'b0;
        flush_i       = 1'b0;
        redirect_pc_i = '0;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_flush_stall();
        test_no_grant();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
